// File: rtl/alu_seq_pkg.sv
// Shared constants for alu_seq: opcodes, flag bit positions and FSM state encodings.
package alu_seq_pkg;

    localparam logic [3:0] OP_ADD   = 4'd0;
    localparam logic [3:0] OP_SUB   = 4'd1;
    localparam logic [3:0] OP_AND   = 4'd2;
    localparam logic [3:0] OP_OR    = 4'd3;
    localparam logic [3:0] OP_XOR   = 4'd4;
    localparam logic [3:0] OP_LOADI = 4'd5;
    localparam logic [3:0] OP_LOAD  = 4'd6;
    localparam logic [3:0] OP_STORE = 4'd7;
    localparam logic [3:0] OP_SHL   = 4'd8;
    localparam logic [3:0] OP_SHR   = 4'd9;
    localparam logic [3:0] OP_SAR   = 4'd10;
    localparam logic [3:0] OP_CMP   = 4'd11;
    localparam logic [3:0] OP_MUL   = 4'd12;

    // flags bus is {Z, N, C, V}
    localparam int FLAG_Z = 3;
    localparam int FLAG_N = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_MUL  = 1'b1;

    function automatic logic [3:0] pack_flags(input logic z, input logic n,
                                              input logic c, input logic v);
        logic [3:0] f;
        f         = '0;
        f[FLAG_Z] = z;
        f[FLAG_N] = n;
        f[FLAG_C] = c;
        f[FLAG_V] = v;
        return f;
    endfunction

endpackage

// File: rtl/alu_mul_seq.sv
// Unsigned shift-add multiplier: one partial-product step per cycle, WIDTH steps total.
// done marks the cycle whose step is the last; prod then shows the finished product.
module alu_mul_seq #(
    parameter int WIDTH = 16
) (
    input  logic               clk,
    input  logic               res,
    input  logic               start,
    input  logic [WIDTH-1:0]   l,
    input  logic [WIDTH-1:0]   r,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] prod
);
    localparam int CW = $clog2(WIDTH);

    logic [WIDTH-1:0]   mcand;
    logic [2*WIDTH-1:0] acc;
    logic [CW-1:0]      cnt;
    logic [WIDTH:0]     step_sum;

    // Upper half accumulates; lower half starts as the multiplier and is consumed LSB first.
    assign step_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mcand} : '0);
    assign prod     = {step_sum, acc[WIDTH-1:1]};
    assign done     = busy && (cnt == CW'(WIDTH - 1));

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            busy  <= 1'b0;
            cnt   <= '0;
            mcand <= '0;
            acc   <= '0;
        end else if (start) begin
            busy  <= 1'b1;
            cnt   <= '0;
            mcand <= l;
            acc   <= {{WIDTH{1'b0}}, r};
        end else if (busy) begin
            acc <= prod;
            cnt <= cnt + 1'b1;
            if (done) begin
                busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_seq.sv
// alu_seq: handshaked ALU with status flags, RAM address output and registered results.
// Define ALU_MUL_EN to build in the multi-cycle MUL opcode and its MUL state.
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int WIDTH      = 16,
    parameter int ADDR_WIDTH = 9,
    parameter int OP_WIDTH   = 4
) (
    input  logic                  clk,
    input  logic                  res,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WIDTH-1:0]      l,
    input  logic [WIDTH-1:0]      r,
    input  logic [OP_WIDTH-1:0]   op,
    output logic [WIDTH-1:0]      o,
    output logic [WIDTH-1:0]      o_hi,
    output logic                  o_oe,
    output logic                  o_valid,
    output logic [ADDR_WIDTH-1:0] a,
    output logic [3:0]            flags
);
    localparam int SHW = $clog2(WIDTH);

    logic [0:0]            state;
    logic                  accept;
    logic [WIDTH:0]        sum;
    logic [WIDTH:0]        diff;
    logic                  v_add;
    logic                  v_sub;
    logic [SHW-1:0]        shamt;
    logic [WIDTH-1:0]      lg;
    logic                  lg_op;
    logic                  is_mul;
    logic [WIDTH-1:0]      o_n;
    logic [ADDR_WIDTH-1:0] a_n;
    logic [3:0]            f_n;
    logic                  oe_n;

    // Handshake: an op is taken on a rising edge with in_valid && in_ready; while a
    // multiply runs in_ready is low and in_valid is ignored, so the requester must hold.
    assign accept = in_valid && in_ready;

    // Carry and borrow both come out of the extra top bit.
    assign sum   = {1'b0, l} + {1'b0, r};
    assign diff  = {1'b0, l} - {1'b0, r};
    assign v_add = (l[WIDTH-1] == r[WIDTH-1]) && (sum[WIDTH-1] != l[WIDTH-1]);
    assign v_sub = (l[WIDTH-1] != r[WIDTH-1]) && (diff[WIDTH-1] != l[WIDTH-1]);
    assign shamt = r[SHW-1:0];

    always_comb begin
        lg    = '0;
        lg_op = 1'b1;
        case (op)
            OP_WIDTH'(OP_AND): lg = l & r;
            OP_WIDTH'(OP_OR):  lg = l | r;
            OP_WIDTH'(OP_XOR): lg = l ^ r;
            OP_WIDTH'(OP_SHL): lg = l << shamt;
            OP_WIDTH'(OP_SHR): lg = l >> shamt;
            OP_WIDTH'(OP_SAR): lg = $signed(l) >>> shamt;
            default:           lg_op = 1'b0;
        endcase
    end

    always_comb begin
        o_n    = '0;
        a_n    = '0;
        f_n    = flags;
        oe_n   = 1'b1;
        is_mul = 1'b0;
        if (lg_op) begin
            o_n = lg;
            f_n = pack_flags(lg == '0, lg[WIDTH-1], 1'b0, 1'b0);
        end else begin
            case (op)
                OP_WIDTH'(OP_ADD): begin
                    o_n = sum[WIDTH-1:0];
                    f_n = pack_flags(sum[WIDTH-1:0] == '0, sum[WIDTH-1], sum[WIDTH], v_add);
                end
                OP_WIDTH'(OP_SUB): begin
                    o_n = diff[WIDTH-1:0];
                    f_n = pack_flags(diff[WIDTH-1:0] == '0, diff[WIDTH-1], diff[WIDTH], v_sub);
                end
                OP_WIDTH'(OP_CMP): begin
                    o_n = o;
                    f_n = pack_flags(diff[WIDTH-1:0] == '0, diff[WIDTH-1], diff[WIDTH], v_sub);
                end
                OP_WIDTH'(OP_LOADI): o_n = r;
                OP_WIDTH'(OP_LOAD): begin
                    a_n  = l[ADDR_WIDTH-1:0];
                    oe_n = 1'b0;
                end
                OP_WIDTH'(OP_STORE): begin
                    o_n = r;
                    a_n = l[ADDR_WIDTH-1:0];
                end
`ifdef ALU_MUL_EN
                OP_WIDTH'(OP_MUL): is_mul = 1'b1;
`endif
                default: o_n = '0;
            endcase
        end
    end

`ifdef ALU_MUL_EN
    logic               mul_busy;
    logic               mul_done;
    logic [2*WIDTH-1:0] mul_prod;

    alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
        .clk   (clk),
        .res   (res),
        .start (accept && is_mul),
        .l     (l),
        .r     (r),
        .busy  (mul_busy),
        .done  (mul_done),
        .prod  (mul_prod)
    );

    assign in_ready = (state == ST_IDLE) && !mul_busy;
`else
    assign in_ready = (state == ST_IDLE);
    assign o_hi     = '0;
`endif

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            state   <= ST_IDLE;
            o       <= '0;
            a       <= '0;
            flags   <= '0;
            o_oe    <= 1'b0;
            o_valid <= 1'b0;
`ifdef ALU_MUL_EN
            o_hi    <= '0;
`endif
        end else begin
            o_valid <= 1'b0;
`ifdef ALU_MUL_EN
            if (state == ST_MUL) begin
                if (mul_done) begin
                    state   <= ST_IDLE;
                    o       <= mul_prod[WIDTH-1:0];
                    o_hi    <= mul_prod[2*WIDTH-1:WIDTH];
                    a       <= '0;
                    o_oe    <= 1'b1;
                    flags   <= pack_flags(mul_prod == '0, 1'b0,
                                          mul_prod[2*WIDTH-1:WIDTH] != '0, 1'b0);
                    o_valid <= 1'b1;
                end
            end else if (accept && is_mul) begin
                state <= ST_MUL;
            end else
`endif
            if (accept) begin
                o       <= o_n;
                a       <= a_n;
                flags   <= f_n;
                o_oe    <= oe_n;
                o_valid <= 1'b1;
`ifdef ALU_MUL_EN
                o_hi    <= '0;
`endif
            end
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq at WIDTH=16; MUL expectations follow whether ALU_MUL_EN is defined.
module tb_alu_seq
    import alu_seq_pkg::*;
;
    logic        clk = 1'b0;
    logic        res;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] l;
    logic [15:0] r;
    logic [3:0]  op;
    logic [15:0] o;
    logic [15:0] o_hi;
    logic        o_oe;
    logic        o_valid;
    logic [8:0]  a;
    logic [3:0]  flags;

    int n_cmp = 0;
    int n_err = 0;

    alu_seq #(.WIDTH(16), .ADDR_WIDTH(9), .OP_WIDTH(4)) dut (
        .clk      (clk),
        .res      (res),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .l        (l),
        .r        (r),
        .op       (op),
        .o        (o),
        .o_hi     (o_hi),
        .o_oe     (o_oe),
        .o_valid  (o_valid),
        .a        (a),
        .flags    (flags)
    );

    always #5 clk = ~clk;

    // Presents one request and returns 1 time unit after the edge that accepts it.
    task automatic drive(input logic [3:0] op_p, input logic [15:0] l_p, input logic [15:0] r_p);
        op       = op_p;
        l        = l_p;
        r        = r_p;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        res      = 1'b0;
        in_valid = 1'b0;
        op       = '0;
        l        = '0;
        r        = '0;
        #2;
        n_cmp++; if (o !== 16'h0000) begin n_err++; $display("FAIL rst_o: got %h want %h", o, 16'h0000); end
        n_cmp++; if (o_hi !== 16'h0000) begin n_err++; $display("FAIL rst_o_hi: got %h want %h", o_hi, 16'h0000); end
        n_cmp++; if (a !== 9'h000) begin n_err++; $display("FAIL rst_a: got %h want %h", a, 9'h000); end
        n_cmp++; if (flags !== 4'b0000) begin n_err++; $display("FAIL rst_flags: got %b want %b", flags, 4'b0000); end
        n_cmp++; if (o_valid !== 1'b0) begin n_err++; $display("FAIL rst_o_valid: got %b want 0", o_valid); end
        n_cmp++; if (o_oe !== 1'b0) begin n_err++; $display("FAIL rst_o_oe: got %b want 0", o_oe); end
        @(posedge clk);
        #1;
        res = 1'b1;
        idle(1);
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL rst_in_ready: got %b want 1", in_ready); end
        n_cmp++; if (o_valid !== 1'b0) begin n_err++; $display("FAIL rst_idle_valid: got %b want 0", o_valid); end
    endtask

    task automatic test_add();
        drive(OP_ADD, 16'hFFFF, 16'h0001);
        n_cmp++; if (o !== 16'h0000) begin n_err++; $display("FAIL add_o: got %h want %h", o, 16'h0000); end
        n_cmp++; if (flags !== 4'b1010) begin n_err++; $display("FAIL add_flags: got %b want %b", flags, 4'b1010); end
        n_cmp++; if (o_valid !== 1'b1) begin n_err++; $display("FAIL add_valid: got %b want 1", o_valid); end
        n_cmp++; if (o_oe !== 1'b1) begin n_err++; $display("FAIL add_oe: got %b want 1", o_oe); end
        drive(OP_ADD, 16'h7FFF, 16'h0001);
        n_cmp++; if (o !== 16'h8000) begin n_err++; $display("FAIL add_ovf_o: got %h want %h", o, 16'h8000); end
        n_cmp++; if (flags !== 4'b0101) begin n_err++; $display("FAIL add_ovf_flags: got %b want %b", flags, 4'b0101); end
        idle(1);
        n_cmp++; if (o_valid !== 1'b0) begin n_err++; $display("FAIL add_pulse: got %b want 0", o_valid); end
        n_cmp++; if (o !== 16'h8000) begin n_err++; $display("FAIL add_hold: got %h want %h", o, 16'h8000); end
    endtask

    task automatic test_sub_cmp();
        drive(OP_SUB, 16'h8000, 16'h0001);
        n_cmp++; if (o !== 16'h7FFF) begin n_err++; $display("FAIL sub_o: got %h want %h", o, 16'h7FFF); end
        n_cmp++; if (flags !== 4'b0001) begin n_err++; $display("FAIL sub_flags: got %b want %b", flags, 4'b0001); end
        drive(OP_CMP, 16'h0001, 16'h0002);
        n_cmp++; if (o !== 16'h7FFF) begin n_err++; $display("FAIL cmp_o: got %h want %h", o, 16'h7FFF); end
        n_cmp++; if (flags !== 4'b0110) begin n_err++; $display("FAIL cmp_flags: got %b want %b", flags, 4'b0110); end
        n_cmp++; if (o_valid !== 1'b1) begin n_err++; $display("FAIL cmp_valid: got %b want 1", o_valid); end
        drive(OP_CMP, 16'h0005, 16'h0005);
        n_cmp++; if (flags !== 4'b1000) begin n_err++; $display("FAIL cmp_eq_flags: got %b want %b", flags, 4'b1000); end
        idle(1);
    endtask

    task automatic test_logic_shift();
        drive(OP_ADD, 16'hFFFF, 16'h0001);
        drive(OP_OR, 16'h8000, 16'h0001);
        n_cmp++; if (o !== 16'h8001) begin n_err++; $display("FAIL or_o: got %h want %h", o, 16'h8001); end
        n_cmp++; if (flags !== 4'b0100) begin n_err++; $display("FAIL or_flags: got %b want %b", flags, 4'b0100); end
        drive(OP_AND, 16'hF0F0, 16'h0FF0);
        n_cmp++; if (o !== 16'h00F0) begin n_err++; $display("FAIL and_o: got %h want %h", o, 16'h00F0); end
        drive(OP_XOR, 16'hAAAA, 16'hAAAA);
        n_cmp++; if (o !== 16'h0000) begin n_err++; $display("FAIL xor_o: got %h want %h", o, 16'h0000); end
        n_cmp++; if (flags !== 4'b1000) begin n_err++; $display("FAIL xor_flags: got %b want %b", flags, 4'b1000); end
        drive(OP_SAR, 16'h8000, 16'h0004);
        n_cmp++; if (o !== 16'hF800) begin n_err++; $display("FAIL sar_o: got %h want %h", o, 16'hF800); end
        n_cmp++; if (flags !== 4'b0100) begin n_err++; $display("FAIL sar_flags: got %b want %b", flags, 4'b0100); end
        drive(OP_SHL, 16'h0001, 16'h0013);
        n_cmp++; if (o !== 16'h0008) begin n_err++; $display("FAIL shl_o: got %h want %h", o, 16'h0008); end
        n_cmp++; if (flags !== 4'b0000) begin n_err++; $display("FAIL shl_flags: got %b want %b", flags, 4'b0000); end
        drive(OP_SHR, 16'h8000, 16'h000F);
        n_cmp++; if (o !== 16'h0001) begin n_err++; $display("FAIL shr_o: got %h want %h", o, 16'h0001); end
        idle(1);
    endtask

    task automatic test_load_store();
        drive(OP_SUB, 16'h8000, 16'h0001);
        drive(OP_LOAD, 16'h01FF, 16'h1111);
        n_cmp++; if (a !== 9'h1FF) begin n_err++; $display("FAIL load_a: got %h want %h", a, 9'h1FF); end
        n_cmp++; if (o_oe !== 1'b0) begin n_err++; $display("FAIL load_oe: got %b want 0", o_oe); end
        n_cmp++; if (o !== 16'h0000) begin n_err++; $display("FAIL load_o: got %h want %h", o, 16'h0000); end
        n_cmp++; if (flags !== 4'b0001) begin n_err++; $display("FAIL load_flags: got %b want %b", flags, 4'b0001); end
        drive(OP_STORE, 16'h0010, 16'hABCD);
        n_cmp++; if (a !== 9'h010) begin n_err++; $display("FAIL store_a: got %h want %h", a, 9'h010); end
        n_cmp++; if (o !== 16'hABCD) begin n_err++; $display("FAIL store_o: got %h want %h", o, 16'hABCD); end
        n_cmp++; if (o_oe !== 1'b1) begin n_err++; $display("FAIL store_oe: got %b want 1", o_oe); end
        drive(OP_LOADI, 16'h0123, 16'h1234);
        n_cmp++; if (o !== 16'h1234) begin n_err++; $display("FAIL loadi_o: got %h want %h", o, 16'h1234); end
        n_cmp++; if (a !== 9'h000) begin n_err++; $display("FAIL loadi_a: got %h want %h", a, 9'h000); end
        n_cmp++; if (flags !== 4'b0001) begin n_err++; $display("FAIL loadi_flags: got %b want %b", flags, 4'b0001); end
        drive(4'd13, 16'h0005, 16'h0006);
        n_cmp++; if (o !== 16'h0000) begin n_err++; $display("FAIL undef_o: got %h want %h", o, 16'h0000); end
        n_cmp++; if (flags !== 4'b0001) begin n_err++; $display("FAIL undef_flags: got %b want %b", flags, 4'b0001); end
        n_cmp++; if (o_valid !== 1'b1) begin n_err++; $display("FAIL undef_valid: got %b want 1", o_valid); end
        idle(1);
    endtask

    task automatic test_mul();
`ifdef ALU_MUL_EN
        drive(OP_STORE, 16'h0021, 16'h5555);
        drive(OP_MUL, 16'h1234, 16'h0100);
        // An ADD is held on the inputs for the whole busy window and must not execute.
        op = OP_ADD;
        l  = 16'h0001;
        r  = 16'h0001;
        n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL mul_ready0: got %b want 0", in_ready); end
        n_cmp++; if (o_valid !== 1'b0) begin n_err++; $display("FAIL mul_valid0: got %b want 0", o_valid); end
        n_cmp++; if (a !== 9'h021) begin n_err++; $display("FAIL mul_a_hold: got %h want %h", a, 9'h021); end
        for (int i = 1; i <= 16; i++) begin
            @(posedge clk);
            #1;
            if (i == 16) in_valid = 1'b0;
            n_cmp++; if (o_valid !== (i == 16)) begin n_err++; $display("FAIL mul_valid edge %0d: got %b want %b", i, o_valid, (i == 16)); end
            if (i < 16) begin
                n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL mul_ready edge %0d: got %b want 0", i, in_ready); end
                n_cmp++; if (o !== 16'h5555) begin n_err++; $display("FAIL mul_o_hold edge %0d: got %h want %h", i, o, 16'h5555); end
            end
        end
        n_cmp++; if (o !== 16'h3400) begin n_err++; $display("FAIL mul_o: got %h want %h", o, 16'h3400); end
        n_cmp++; if (o_hi !== 16'h0012) begin n_err++; $display("FAIL mul_o_hi: got %h want %h", o_hi, 16'h0012); end
        n_cmp++; if (flags !== 4'b0010) begin n_err++; $display("FAIL mul_flags: got %b want %b", flags, 4'b0010); end
        n_cmp++; if (a !== 9'h000) begin n_err++; $display("FAIL mul_a: got %h want %h", a, 9'h000); end
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL mul_ready_end: got %b want 1", in_ready); end
        idle(1);
        n_cmp++; if (o_valid !== 1'b0) begin n_err++; $display("FAIL mul_pulse: got %b want 0", o_valid); end
        n_cmp++; if (o !== 16'h3400) begin n_err++; $display("FAIL mul_no_add: got %h want %h", o, 16'h3400); end
        drive(OP_ADD, 16'h0002, 16'h0003);
        n_cmp++; if (o_hi !== 16'h0000) begin n_err++; $display("FAIL mul_hi_clear: got %h want %h", o_hi, 16'h0000); end
        n_cmp++; if (o !== 16'h0005) begin n_err++; $display("FAIL mul_next_add: got %h want %h", o, 16'h0005); end
        idle(1);
`else
        drive(OP_SUB, 16'h8000, 16'h0001);
        drive(OP_MUL, 16'h1234, 16'h0100);
        n_cmp++; if (o !== 16'h0000) begin n_err++; $display("FAIL mul_off_o: got %h want %h", o, 16'h0000); end
        n_cmp++; if (o_hi !== 16'h0000) begin n_err++; $display("FAIL mul_off_hi: got %h want %h", o_hi, 16'h0000); end
        n_cmp++; if (flags !== 4'b0001) begin n_err++; $display("FAIL mul_off_flags: got %b want %b", flags, 4'b0001); end
        n_cmp++; if (o_valid !== 1'b1) begin n_err++; $display("FAIL mul_off_valid: got %b want 1", o_valid); end
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL mul_off_ready: got %b want 1", in_ready); end
        idle(1);
        n_cmp++; if (o_valid !== 1'b0) begin n_err++; $display("FAIL mul_off_pulse: got %b want 0", o_valid); end
`endif
    endtask

    task automatic test_reset_mid_mul();
        int pulses;
        drive(OP_SUB, 16'h8000, 16'h0001);
        drive(OP_MUL, 16'h00FF, 16'h00FF);
        idle(4);
        res = 1'b0;
        #1;
        n_cmp++; if (o !== 16'h0000) begin n_err++; $display("FAIL mrst_o: got %h want %h", o, 16'h0000); end
        n_cmp++; if (o_hi !== 16'h0000) begin n_err++; $display("FAIL mrst_o_hi: got %h want %h", o_hi, 16'h0000); end
        n_cmp++; if (flags !== 4'b0000) begin n_err++; $display("FAIL mrst_flags: got %b want %b", flags, 4'b0000); end
        n_cmp++; if (a !== 9'h000) begin n_err++; $display("FAIL mrst_a: got %h want %h", a, 9'h000); end
        n_cmp++; if (o_oe !== 1'b0) begin n_err++; $display("FAIL mrst_oe: got %b want 0", o_oe); end
        n_cmp++; if (o_valid !== 1'b0) begin n_err++; $display("FAIL mrst_valid: got %b want 0", o_valid); end
        @(posedge clk);
        #1;
        res    = 1'b1;
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (o_valid === 1'b1) pulses++;
        end
        n_cmp++; if (pulses != 0) begin n_err++; $display("FAIL mrst_no_pulse: got %0d want 0", pulses); end
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL mrst_ready: got %b want 1", in_ready); end
        drive(OP_ADD, 16'h0002, 16'h0003);
        n_cmp++; if (o !== 16'h0005) begin n_err++; $display("FAIL mrst_add_o: got %h want %h", o, 16'h0005); end
        n_cmp++; if (o_valid !== 1'b1) begin n_err++; $display("FAIL mrst_add_valid: got %b want 1", o_valid); end
        idle(1);
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub_cmp();
        test_logic_shift();
        test_load_store();
        test_mul();
        test_reset_mid_mul();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
